// File: rtl/dti_monitor_pkg.sv
// Shared definitions for the DTI link monitor: violation bit positions,
// the sticky-flag vector type and a saturating increment helper.
// Optional feature macro used by this codebase: DTI_MONITOR_STALL_CNT_EN.
package dti_monitor_pkg;

    localparam int VIOL_DROP = 0;
    localparam int VIOL_DATA = 1;
    localparam int N_VIOL    = 2;

    typedef logic [N_VIOL-1:0] viol_t;

    // Increment val, holding at the all-ones value of a width-bit counter.
    // Works on a 64-bit container; callers cast to their own width (<= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val == max_v) ? val : (val + 64'd1);
    endfunction

endpackage

// File: rtl/dti_monitor_ch.sv
// One monitored DTI channel: handshake counter, last data, pending tracker and
// sticky protocol flags; stall counter only with DTI_MONITOR_STALL_CNT_EN.
// Next-state values are exported so the readout shows post-update state.
module dti_monitor_ch
    import dti_monitor_pkg::*;
#(
    parameter int W_DATA = 64,
    parameter int W_CNT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              valid,
    input  logic              ready,
    input  logic [W_DATA-1:0] data,
    output logic [W_CNT-1:0]  hs_cnt_nxt,
    output logic [W_CNT-1:0]  stall_cnt_nxt,
    output logic [W_DATA-1:0] last_nxt,
    output viol_t             viol_nxt,
    output viol_t             viol
);

    logic              hs;
    logic              stall;
    logic              ev_drop;
    logic              ev_chg;

    logic              pending_q, pending_d;
    logic [W_DATA-1:0] hold_data_q, hold_data_d;
    logic [W_CNT-1:0]  hs_cnt_q, hs_cnt_d;
    logic [W_DATA-1:0] last_data_q, last_data_d;
    viol_t             viol_q, viol_d;

    // Next-state logic for handshake tracking, violation detection and clear.
    always_comb begin
        hs      = valid && ready;
        stall   = valid && !ready;
        // A stalled beat must stay valid with stable data until it is taken.
        ev_drop = pending_q && !valid;
        ev_chg  = pending_q && valid && (data != hold_data_q);

        pending_d   = stall;
        // Capture on the first stalled cycle only; later beats compare against it.
        hold_data_d = (stall && !pending_q) ? data : hold_data_q;
        last_data_d = hs ? data : last_data_q;
        hs_cnt_d    = hs ? W_CNT'(sat_inc(64'(hs_cnt_q), W_CNT)) : hs_cnt_q;

        viol_d = viol_q;
        if (ev_drop) viol_d[VIOL_DROP] = 1'b1;
        if (ev_chg)  viol_d[VIOL_DATA] = 1'b1;

        // clr wins over same-cycle events; last data and pending still advance.
        if (clr) begin
            hs_cnt_d = '0;
            viol_d   = '0;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            hold_data_q <= '0;
            hs_cnt_q    <= '0;
            last_data_q <= '0;
            viol_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            hold_data_q <= hold_data_d;
            hs_cnt_q    <= hs_cnt_d;
            last_data_q <= last_data_d;
            viol_q      <= viol_d;
        end
    end

`ifdef DTI_MONITOR_STALL_CNT_EN
    logic [W_CNT-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles spent with valid high and ready low.
    always_comb begin
        stall_cnt_d = stall ? W_CNT'(sat_inc(64'(stall_cnt_q), W_CNT)) : stall_cnt_q;
        if (clr) stall_cnt_d = '0;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_nxt = rst ? '0 : stall_cnt_d;
`else
    assign stall_cnt_nxt = '0;
`endif

    // Reset forces the exported next state to zero so readout clears with it.
    assign hs_cnt_nxt = rst ? '0 : hs_cnt_d;
    assign last_nxt   = rst ? '0 : last_data_d;
    assign viol_nxt   = rst ? '0 : viol_d;
    assign viol       = viol_q;

endmodule

// File: rtl/dti_monitor.sv
// Passive N-channel DTI monitor: per-channel stats with a registered readout port.
// Readout latency 1 cycle (shows state after the sampling edge); never drives the bus.
// Optional stall counters via DTI_MONITOR_STALL_CNT_EN; otherwise rd_stall_cnt reads 0.
module dti_monitor
    import dti_monitor_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W_DATA = 64,
    parameter int W_CNT  = 32,
    parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*W_DATA-1:0]   din_data,
    input  logic [N_CH-1:0]          din_valid,
    input  logic [N_CH-1:0]          din_ready,
    input  logic                     clr,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [W_CNT-1:0]         rd_hs_cnt,
    output logic [W_CNT-1:0]         rd_stall_cnt,
    output logic [W_DATA-1:0]        rd_last,
    output logic [N_VIOL-1:0]        rd_viol,
    output logic                     viol_any
);

    logic [W_CNT-1:0]  ch_hs_nxt    [N_CH];
    logic [W_CNT-1:0]  ch_stall_nxt [N_CH];
    logic [W_DATA-1:0] ch_last_nxt  [N_CH];
    viol_t             ch_viol_nxt  [N_CH];
    viol_t             ch_viol      [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        dti_monitor_ch #(
            .W_DATA (W_DATA),
            .W_CNT  (W_CNT)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .clr           (clr),
            .valid         (din_valid[i]),
            .ready         (din_ready[i]),
            .data          (din_data[i*W_DATA +: W_DATA]),
            .hs_cnt_nxt    (ch_hs_nxt[i]),
            .stall_cnt_nxt (ch_stall_nxt[i]),
            .last_nxt      (ch_last_nxt[i]),
            .viol_nxt      (ch_viol_nxt[i]),
            .viol          (ch_viol[i])
        );
    end

    logic [W_CNT-1:0]  rd_hs_cnt_q, rd_hs_cnt_d;
    logic [W_CNT-1:0]  rd_stall_cnt_q, rd_stall_cnt_d;
    logic [W_DATA-1:0] rd_last_q, rd_last_d;
    viol_t             rd_viol_q, rd_viol_d;
    logic              viol_or;

    // Readout mux: out-of-range selects read as zero.
    always_comb begin
        rd_hs_cnt_d    = '0;
        rd_stall_cnt_d = '0;
        rd_last_d      = '0;
        rd_viol_d      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_hs_cnt_d    = ch_hs_nxt[i];
                rd_stall_cnt_d = ch_stall_nxt[i];
                rd_last_d      = ch_last_nxt[i];
                rd_viol_d      = ch_viol_nxt[i];
            end
        end
    end

    // Readout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hs_cnt_q    <= '0;
            rd_stall_cnt_q <= '0;
            rd_last_q      <= '0;
            rd_viol_q      <= '0;
        end else begin
            rd_hs_cnt_q    <= rd_hs_cnt_d;
            rd_stall_cnt_q <= rd_stall_cnt_d;
            rd_last_q      <= rd_last_d;
            rd_viol_q      <= rd_viol_d;
        end
    end

    // Any sticky flag on any channel.
    always_comb begin
        viol_or = 1'b0;
        for (int i = 0; i < N_CH; i++) viol_or = viol_or | (|ch_viol[i]);
    end

    assign rd_hs_cnt    = rd_hs_cnt_q;
    assign rd_stall_cnt = rd_stall_cnt_q;
    assign rd_last      = rd_last_q;
    assign rd_viol      = rd_viol_q;
    assign viol_any     = viol_or;

endmodule

// File: tb/tb_dti_monitor.sv
// Directed bench for dti_monitor: main instance N_CH=4/W_CNT=4 plus a
// three-channel instance so an out-of-range rd_sel is representable.
module tb_dti_monitor;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [255:0]  din_data;
    logic [3:0]    din_valid;
    logic [3:0]    din_ready;
    logic [1:0]    rd_sel;
    logic [3:0]    rd_hs_cnt;
    logic [3:0]    rd_stall_cnt;
    logic [63:0]   rd_last;
    logic [1:0]    rd_viol;
    logic          viol_any;

    logic [23:0]   b_data;
    logic [2:0]    b_valid;
    logic [2:0]    b_ready;
    logic [1:0]    b_sel;
    logic [7:0]    b_hs_cnt;
    logic [7:0]    b_stall_cnt;
    logic [7:0]    b_last;
    logic [1:0]    b_viol;
    logic          b_viol_any;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_stall;

    always #5 clk = ~clk;

    dti_monitor #(.N_CH(4), .W_DATA(64), .W_CNT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_data     (din_data),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .clr          (clr),
        .rd_sel       (rd_sel),
        .rd_hs_cnt    (rd_hs_cnt),
        .rd_stall_cnt (rd_stall_cnt),
        .rd_last      (rd_last),
        .rd_viol      (rd_viol),
        .viol_any     (viol_any)
    );

    dti_monitor #(.N_CH(3), .W_DATA(8), .W_CNT(8)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .din_data     (b_data),
        .din_valid    (b_valid),
        .din_ready    (b_ready),
        .clr          (clr),
        .rd_sel       (b_sel),
        .rd_hs_cnt    (b_hs_cnt),
        .rd_stall_cnt (b_stall_cnt),
        .rd_last      (b_last),
        .rd_viol      (b_viol),
        .viol_any     (b_viol_any)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        din_data = '0; din_valid = '0; din_ready = '0; rd_sel = 2'd0;
        b_data = '0; b_valid = '0; b_ready = '0; b_sel = 2'd0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_hs",    64'(rd_hs_cnt), 64'd0);
        check("reset_stall", 64'(rd_stall_cnt), 64'd0);
        check("reset_last",  rd_last, 64'd0);
        check("reset_viol",  64'(rd_viol), 64'd0);
        check("reset_any",   64'(viol_any), 64'd0);

        // Ch0: four back-to-back handshakes.
        rd_sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            din_valid[0] = 1'b1; din_ready[0] = 1'b1;
            din_data[0*64 +: 64] = 64'hA0 + 64'(k);
            step();
        end
        din_valid[0] = 1'b0; din_ready[0] = 1'b0;
        step();
        check("ch0_hs",   64'(rd_hs_cnt), 64'd4);
        check("ch0_last", rd_last, 64'hA3);
        check("ch0_viol", 64'(rd_viol), 64'd0);
        check("ch0_any",  64'(viol_any), 64'd0);

        // Ch1: three stalled cycles then valid drops.
        rd_sel = 2'd1;
        din_valid[1] = 1'b1; din_ready[1] = 1'b0; din_data[1*64 +: 64] = 64'h55;
        step(); step(); step();
        check("ch1_any_pre", 64'(viol_any), 64'd0);
        din_valid[1] = 1'b0;
        step();
`ifdef DTI_MONITOR_STALL_CNT_EN
        exp_stall = 64'd3;
`else
        exp_stall = 64'd0;
`endif
        check("ch1_viol",  64'(rd_viol), 64'b01);
        check("ch1_any",   64'(viol_any), 64'd1);
        check("ch1_stall", 64'(rd_stall_cnt), exp_stall);
        check("ch1_hs",    64'(rd_hs_cnt), 64'd0);

        // Ch2: data changes while stalled, then the handshake completes.
        rd_sel = 2'd2;
        din_valid[2] = 1'b1; din_ready[2] = 1'b0; din_data[2*64 +: 64] = 64'h11;
        step();
        din_data[2*64 +: 64] = 64'h22;
        step();
        din_ready[2] = 1'b1;
        step();
        din_valid[2] = 1'b0; din_ready[2] = 1'b0;
        step();
        check("ch2_viol", 64'(rd_viol), 64'b10);
        check("ch2_hs",   64'(rd_hs_cnt), 64'd1);
        check("ch2_last", rd_last, 64'h22);

        // Ch3: twenty handshakes on a 4-bit counter saturate at 15.
        rd_sel = 2'd3;
        for (int k = 0; k < 20; k++) begin
            din_valid[3] = 1'b1; din_ready[3] = 1'b1;
            din_data[3*64 +: 64] = 64'(k);
            step();
            if (k == 13) check("ch3_hs_14", 64'(rd_hs_cnt), 64'd14);
        end
        din_valid[3] = 1'b0; din_ready[3] = 1'b0;
        step();
        check("ch3_hs_sat", 64'(rd_hs_cnt), 64'd15);
        check("ch3_last",   rd_last, 64'h13);

        // clr coincident with a ch0 handshake of 0x77.
        rd_sel = 2'd0; clr = 1'b1;
        din_valid[0] = 1'b1; din_ready[0] = 1'b1; din_data[0*64 +: 64] = 64'h77;
        step();
        clr = 1'b0; din_valid[0] = 1'b0; din_ready[0] = 1'b0;
        check("clr_hs",    64'(rd_hs_cnt), 64'd0);
        check("clr_last",  rd_last, 64'h77);
        check("clr_viol",  64'(rd_viol), 64'd0);
        check("clr_any",   64'(viol_any), 64'd0);
        rd_sel = 2'd2;
        step();
        check("clr_ch2_viol", 64'(rd_viol), 64'd0);
        check("clr_ch2_last", rd_last, 64'h22);
        check("clr_ch2_stall", 64'(rd_stall_cnt), 64'd0);

        // Reset in the middle of a ch1 stall.
        rd_sel = 2'd1;
        din_valid[1] = 1'b1; din_ready[1] = 1'b0; din_data[1*64 +: 64] = 64'h99;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; din_valid[1] = 1'b0;
        step(); step();
        check("rst_viol",  64'(rd_viol), 64'd0);
        check("rst_any",   64'(viol_any), 64'd0);
        check("rst_hs",    64'(rd_hs_cnt), 64'd0);
        check("rst_stall", 64'(rd_stall_cnt), 64'd0);
        check("rst_last",  rd_last, 64'd0);
        rd_sel = 2'd0;
        step();
        check("rst_ch0_last", rd_last, 64'd0);

        // Simultaneous handshakes on all channels.
        din_valid = 4'hF; din_ready = 4'hF;
        for (int c = 0; c < 4; c++) din_data[c*64 +: 64] = 64'hC0 + 64'(c);
        step();
        din_valid = 4'h0; din_ready = 4'h0;
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            step();
            check("all_hs",   64'(rd_hs_cnt), 64'd1);
            check("all_last", rd_last, 64'hC0 + 64'(c));
        end

        // Three-channel instance: in-range then out-of-range select.
        b_sel = 2'd2;
        b_valid[2] = 1'b1; b_ready[2] = 1'b1; b_data[2*8 +: 8] = 8'h5A;
        step();
        b_valid[2] = 1'b0; b_ready[2] = 1'b0;
        check("b_ch2_hs",   64'(b_hs_cnt), 64'd1);
        check("b_ch2_last", 64'(b_last), 64'h5A);
        b_sel = 2'd3;
        step();
        check("b_oor_hs",   64'(b_hs_cnt), 64'd0);
        check("b_oor_last", 64'(b_last), 64'd0);
        check("b_oor_viol", 64'(b_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
